vending_ctrl_param: RTL and testbench
=====================================

Name: vending_ctrl_param

Overview:
- Parametrised successor to the single-product water vending FSM.
- Accepts coins of four denominations and accumulates credit up to a configurable ceiling.
- Supports N_PROD products with individual prices and handshakes each vend with the dispenser.
- Returns change or a cancel refund as a greedy, largest-coin-first sequence, one coin per ACK handshake.
- Sits between the coin acceptor/keypad front end and the product and coin dispensers.

Parameters:
- CREDIT_W, 8: credit register width in units of 10 cents.
- N_PROD, 4: number of selectable products.
- SEL_W, 2: width of product select, equal to clog2(N_PROD).
- PRICES, {15,12,8,5}: flat vector N_PROD*CREDIT_W wide. Product i price is at [i*CREDIT_W +: CREDIT_W], in 10c units.
- MAX_CREDIT, 20: highest credit accepted, in 10c units.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- COIN_VALID  in  1  one-cycle strobe: a coin was inserted.
- COIN_SEL  in  2  coin value (keeps the M0/M1 encoding): 00=10c, 01=20c, 10=50c, 11=100c.
- SEL_VALID  in  1  one-cycle strobe: product selected.
- SEL_ID  in  SEL_W  selected product index.
- CANCEL  in  1  one-cycle strobe: refund request.
- VEND_READY  in  1  dispenser accepts the vend.
- CHG_ACK  in  1  coin dispenser accepts the current change coin.
- BEBIDA  out  1  vend request; held until VEND_READY.
- BEBIDA_ID  out  SEL_W  product being vended; valid while BEBIDA=1.
- CHG_VALID  out  1  change coin request.
- CHG_COIN  out  2  change coin value, same encoding as COIN_SEL.
- CREDIT  out  CREDIT_W  current credit.
- COIN_REJ  out  1  one-cycle pulse: coin refused; acceptor returns it.
- SEL_REJ  out  1  one-cycle pulse: selection refused.
- BUSY  out  1  high in VEND and CHANGE.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, CREDIT=0.
  - All outputs 0, BEBIDA_ID=0.
  - Pending vend or change is discarded.
- Coin values in units: 1, 2, 5, 10.
- States:
  - IDLE: CREDIT=0.
  - HOLD: CREDIT>0.
  - VEND.
  - CHANGE.
- Registered outputs: every effect (CREDIT update, strobes, state change) is visible the cycle after the sampling edge.
- Input priority in IDLE/HOLD, same cycle: CANCEL > SEL_VALID > COIN_VALID. A lower-priority strobe in that cycle is dropped; a dropped coin pulses COIN_REJ.
- COIN_VALID in IDLE/HOLD:
  - If CREDIT+value <= MAX_CREDIT: CREDIT+=value, go to HOLD.
  - Else: COIN_REJ pulse, CREDIT unchanged.
  - The sum is computed at CREDIT_W+1 bits, so no wrap.
- SEL_VALID in IDLE/HOLD:
  - If SEL_ID >= N_PROD or CREDIT < price: SEL_REJ pulse, state unchanged.
  - Else: latch SEL_ID and price, go to VEND.
- CANCEL:
  - In HOLD: go to CHANGE; the refund amount is the full CREDIT.
  - In IDLE: ignored, no pulse.
- VEND:
  - BEBIDA=1 and BEBIDA_ID stable until the cycle where BEBIDA & VEND_READY.
  - On that handshake: CREDIT -= price; go to CHANGE if the result is >0, else IDLE.
  - BEBIDA drops the next cycle.
- CHANGE:
  - CHG_VALID=1; CHG_COIN is the largest denomination <= CREDIT.
  - CHG_COIN is held stable while CHG_ACK=0.
  - On CHG_VALID & CHG_ACK: CREDIT -= coin value.
  - The next coin is presented the following cycle; no idle gap is required.
  - When CREDIT reaches 0: CHG_VALID=0, go to IDLE.
- In VEND/CHANGE:
  - COIN_VALID produces a COIN_REJ pulse.
  - SEL_VALID produces a SEL_REJ pulse.
  - CANCEL is ignored.
- CREDIT never underflows: a vend requires CREDIT >= price, and change subtracts at most CREDIT.
- BUSY = (state==VEND) | (state==CHANGE).

Test Plan:
- Vend exact amount: coins 20,20,10 -> CREDIT 2,4,5. SEL_ID=0 -> BEBIDA=1, BEBIDA_ID=0. VEND_READY after 2 cycles -> BEBIDA held, then 0. No CHG_VALID. State IDLE, CREDIT=0.
- Vend with change: coin 100, SEL_ID=1 (price 8) -> vend handshake, CREDIT=2. CHG_VALID with CHG_COIN=01; on ACK, CREDIT=0 and IDLE.
- Cancel refund: coins 100,50,20 (CREDIT=17), then CANCEL -> change coins 11,10,01 in order. CHG_ACK delayed 3 cycles on each coin; CHG_COIN and CHG_VALID stay stable while waiting. CREDIT steps 7,2,0.
- Credit ceiling and busy rejection:
  - coins 100,100 -> CREDIT=20; coin 10 -> COIN_REJ, CREDIT=20.
  - SEL_ID=3 (price 15) -> vend; coin during VEND -> COIN_REJ. Change is a single 10 (50c) coin.
- Selection rules: CREDIT=5, SEL_ID=2 (price 12) -> SEL_REJ, CREDIT=5. CANCEL and SEL_VALID (SEL_ID=0) in the same cycle -> refund of 5 (CHG_COIN=10), no BEBIDA.
- Reset mid-operation: RST_N low while CHG_VALID=1 and CHG_ACK=0 -> same cycle, all outputs 0 and CREDIT=0. After release, state IDLE and the next coin is accepted normally.

Source files
------------

// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param
//   Multi-product vending controller. Accumulates coin credit up to a ceiling,
//   vends one of N_PROD products through a ready/valid style handshake with
//   the product dispenser, and pays change or a cancel refund one coin at a
//   time (largest denomination first) through an ACK handshake with the coin
//   dispenser. Credit is kept in units of 10 cents.
//
// Ports
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset
//   COIN_VALID  coin inserted strobe; COIN_SEL gives its value
//               (00=10c, 01=20c, 10=50c, 11=100c)
//   SEL_VALID   product selection strobe; SEL_ID gives the product index
//   CANCEL      refund request strobe
//   VEND_READY  product dispenser accepts the pending vend
//   CHG_ACK     coin dispenser accepts the presented change coin
//   BEBIDA      vend request, held until VEND_READY; BEBIDA_ID is the product
//   CHG_VALID   change coin request; CHG_COIN is the coin value
//   CREDIT      current credit
//   COIN_REJ    one-cycle pulse, coin refused
//   SEL_REJ     one-cycle pulse, selection refused
//   BUSY        vend or change in progress
//
// States
//   IDLE   | no credit, waiting for a coin
//   HOLD   | credit > 0, waiting for coin / selection / cancel
//   VEND   | vend request presented, waiting for VEND_READY
//   CHANGE | paying back remaining credit one coin per CHG_ACK

module vending_ctrl_param #(
    parameter int                         CREDIT_W   = 8,
    parameter int                         N_PROD     = 4,
    parameter int                         SEL_W      = 2,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {8'd15, 8'd12, 8'd8, 8'd5},
    parameter int                         MAX_CREDIT = 20
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                COIN_VALID,
    input  logic [1:0]          COIN_SEL,
    input  logic                SEL_VALID,
    input  logic [SEL_W-1:0]    SEL_ID,
    input  logic                CANCEL,
    input  logic                VEND_READY,
    input  logic                CHG_ACK,
    output logic                BEBIDA,
    output logic [SEL_W-1:0]    BEBIDA_ID,
    output logic                CHG_VALID,
    output logic [1:0]          CHG_COIN,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                COIN_REJ,
    output logic                SEL_REJ,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam logic [CREDIT_W:0] MAX_L = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                coin_rej_q, coin_rej_d;
    logic                sel_rej_q, sel_rej_d;

    logic [CREDIT_W:0]   coin_sum;
    logic [1:0]          chg_coin_w;
    logic [CREDIT_W-1:0] chg_units;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;

    function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] c);
        logic [CREDIT_W-1:0] u;
        case (c)
            2'b00:   u = CREDIT_W'(1);
            2'b01:   u = CREDIT_W'(2);
            2'b10:   u = CREDIT_W'(5);
            default: u = CREDIT_W'(10);
        endcase
        return u;
    endfunction

    // Largest denomination that does not exceed the remaining credit.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        logic [1:0] r;
        if (c >= CREDIT_W'(10))     r = 2'b11;
        else if (c >= CREDIT_W'(5)) r = 2'b10;
        else if (c >= CREDIT_W'(2)) r = 2'b01;
        else                        r = 2'b00;
        return r;
    endfunction

    // Out-of-range indices return 0; they are rejected by sel_ok anyway.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] id);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (int'(id) == i) p = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        return p;
    endfunction

    always_comb begin
        coin_sum   = {1'b0, credit_q} + {1'b0, coin_units(COIN_SEL)};
        chg_coin_w = greedy_coin(credit_q);
        chg_units  = coin_units(chg_coin_w);
        sel_price  = price_of(SEL_ID);
        sel_ok     = (int'(SEL_ID) < N_PROD) && (credit_q >= sel_price);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            price_q    <= '0;
            sel_q      <= '0;
            coin_rej_q <= 1'b0;
            sel_rej_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            price_q    <= price_d;
            sel_q      <= sel_d;
            coin_rej_q <= coin_rej_d;
            sel_rej_q  <= sel_rej_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        price_d    = price_q;
        sel_d      = sel_q;
        coin_rej_d = 1'b0;
        sel_rej_d  = 1'b0;

        case (state_q)
            S_IDLE, S_HOLD: begin
                // CANCEL only takes effect (and only pre-empts the other
                // strobes) when there is credit to refund.
                if (CANCEL && state_q == S_HOLD) begin
                    state_d    = S_CHANGE;
                    coin_rej_d = COIN_VALID;
                end else if (SEL_VALID) begin
                    if (sel_ok) begin
                        sel_d   = SEL_ID;
                        price_d = sel_price;
                        state_d = S_VEND;
                    end else begin
                        sel_rej_d = 1'b1;
                    end
                    coin_rej_d = COIN_VALID;
                end else if (COIN_VALID) begin
                    if (coin_sum <= MAX_L) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_HOLD;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end

            S_VEND: begin
                coin_rej_d = COIN_VALID;
                sel_rej_d  = SEL_VALID;
                if (VEND_READY) begin
                    credit_d = credit_q - price_q;
                    state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
                end
            end

            S_CHANGE: begin
                coin_rej_d = COIN_VALID;
                sel_rej_d  = SEL_VALID;
                if (CHG_ACK) begin
                    credit_d = credit_q - chg_units;
                    if (credit_d == '0) state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // All outputs decode registered state, so they change only after an edge
    // (or immediately on reset).
    always_comb begin
        BEBIDA    = (state_q == S_VEND);
        BEBIDA_ID = BEBIDA ? sel_q : '0;
        CHG_VALID = (state_q == S_CHANGE);
        CHG_COIN  = CHG_VALID ? chg_coin_w : 2'b00;
        CREDIT    = credit_q;
        COIN_REJ  = coin_rej_q;
        SEL_REJ   = sel_rej_q;
        BUSY      = (state_q == S_VEND) || (state_q == S_CHANGE);
    end

endmodule

// File: tb/tb_vending_ctrl_param.sv
module tb_vending_ctrl_param;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       COIN_VALID = 1'b0;
    logic [1:0] COIN_SEL = 2'b00;
    logic       SEL_VALID = 1'b0;
    logic [1:0] SEL_ID = 2'b00;
    logic       CANCEL = 1'b0;
    logic       VEND_READY = 1'b0;
    logic       CHG_ACK = 1'b0;
    logic       BEBIDA;
    logic [1:0] BEBIDA_ID;
    logic       CHG_VALID;
    logic [1:0] CHG_COIN;
    logic [7:0] CREDIT;
    logic       COIN_REJ;
    logic       SEL_REJ;
    logic       BUSY;

    vending_ctrl_param dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .COIN_VALID (COIN_VALID),
        .COIN_SEL   (COIN_SEL),
        .SEL_VALID  (SEL_VALID),
        .SEL_ID     (SEL_ID),
        .CANCEL     (CANCEL),
        .VEND_READY (VEND_READY),
        .CHG_ACK    (CHG_ACK),
        .BEBIDA     (BEBIDA),
        .BEBIDA_ID  (BEBIDA_ID),
        .CHG_VALID  (CHG_VALID),
        .CHG_COIN   (CHG_COIN),
        .CREDIT     (CREDIT),
        .COIN_REJ   (COIN_REJ),
        .SEL_REJ    (SEL_REJ),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Scoreboard: expected items pushed when stimulus is driven,
    // observed items collected while the DUT produces them.
    int exp_coin[$];
    int exp_cred[$];
    int exp_vend[$];
    int obs_coin[$];
    int obs_cred[$];
    logic unstable;
    logic timeout;

    // Expected refund sequence: largest denomination first.
    function automatic void push_refund(input int amount);
        int amt;
        amt = amount;
        while (amt > 0) begin
            if (amt >= 10) begin
                exp_coin.push_back(3); amt -= 10;
            end else if (amt >= 5) begin
                exp_coin.push_back(2); amt -= 5;
            end else if (amt >= 2) begin
                exp_coin.push_back(1); amt -= 2;
            end else begin
                exp_coin.push_back(0); amt -= 1;
            end
            exp_cred.push_back(amt);
        end
    endfunction

    // Stimulus: one-cycle coin strobe; returns with the effect visible.
    task automatic drive_coin(input logic [1:0] c);
        COIN_SEL = c;
        COIN_VALID = 1'b1;
        @(negedge CLK);
        COIN_VALID = 1'b0;
    endtask

    task automatic drive_sel(input logic [1:0] id);
        SEL_ID = id;
        SEL_VALID = 1'b1;
        @(negedge CLK);
        SEL_VALID = 1'b0;
    endtask

    task automatic drive_cancel();
        CANCEL = 1'b1;
        @(negedge CLK);
        CANCEL = 1'b0;
    endtask

    // Acknowledges change coins after 'delay' idle cycles each, recording
    // the coin and the resulting credit. Bounded by a cycle budget.
    task automatic drain_change(input int delay);
        int guard;
        logic [1:0] c;
        unstable = 1'b0;
        timeout = 1'b0;
        guard = 0;
        obs_coin.delete();
        obs_cred.delete();
        while (CHG_VALID !== 1'b1 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        while (CHG_VALID === 1'b1 && guard < 200) begin
            c = CHG_COIN;
            for (int d = 0; d < delay; d++) begin
                @(negedge CLK);
                guard++;
                if (CHG_VALID !== 1'b1 || CHG_COIN !== c) unstable = 1'b1;
            end
            CHG_ACK = 1'b1;
            @(negedge CLK);
            CHG_ACK = 1'b0;
            guard++;
            obs_coin.push_back(int'(c));
            obs_cred.push_back(int'(CREDIT));
        end
        if (CHG_VALID === 1'b1) timeout = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({BEBIDA, BEBIDA_ID, CHG_VALID, CHG_COIN, CREDIT, COIN_REJ, SEL_REJ, BUSY} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {BEBIDA, BEBIDA_ID, CHG_VALID, CHG_COIN, CREDIT, COIN_REJ, SEL_REJ, BUSY});
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (CREDIT !== 8'd0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: credit=%0d busy=%b expected 0/0", CREDIT, BUSY);
        end
    endtask

    task automatic test_vend_exact();
        int exp_c[3];
        logic [1:0] coins[3];
        int v;
        coins[0] = 2'b01; coins[1] = 2'b01; coins[2] = 2'b00;
        exp_c[0] = 2; exp_c[1] = 4; exp_c[2] = 5;
        for (int i = 0; i < 3; i++) begin
            drive_coin(coins[i]);
            checks++;
            if (CREDIT !== 8'(exp_c[i]) || COIN_REJ !== 1'b0) begin
                errors++;
                $display("FAIL exact_credit[%0d]: credit=%0d rej=%b expected %0d/0", i, CREDIT, COIN_REJ, exp_c[i]);
            end
        end
        exp_vend.push_back(0);
        drive_sel(2'd0);
        v = exp_vend.pop_front();
        checks++;
        if (BEBIDA !== 1'b1 || BEBIDA_ID !== 2'(v) || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL exact_vend_req: bebida=%b id=%0d busy=%b expected 1/%0d/1", BEBIDA, BEBIDA_ID, BUSY, v);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (BEBIDA !== 1'b1 || BEBIDA_ID !== 2'(v)) begin
                errors++;
                $display("FAIL exact_vend_hold[%0d]: bebida=%b id=%0d expected 1/%0d", i, BEBIDA, BEBIDA_ID, v);
            end
        end
        VEND_READY = 1'b1;
        @(negedge CLK);
        VEND_READY = 1'b0;
        checks++;
        if (BEBIDA !== 1'b0 || CHG_VALID !== 1'b0 || CREDIT !== 8'd0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL exact_done: bebida=%b chg=%b credit=%0d busy=%b expected 0/0/0/0",
                     BEBIDA, CHG_VALID, CREDIT, BUSY);
        end
    endtask

    task automatic test_vend_change();
        int v;
        drive_coin(2'b11);
        exp_vend.push_back(1);
        drive_sel(2'd1);
        v = exp_vend.pop_front();
        checks++;
        if (BEBIDA !== 1'b1 || BEBIDA_ID !== 2'(v)) begin
            errors++;
            $display("FAIL change_vend_req: bebida=%b id=%0d expected 1/%0d", BEBIDA, BEBIDA_ID, v);
        end
        VEND_READY = 1'b1;
        @(negedge CLK);
        VEND_READY = 1'b0;
        checks++;
        if (BEBIDA !== 1'b0 || CREDIT !== 8'd2 || CHG_VALID !== 1'b1) begin
            errors++;
            $display("FAIL change_after_vend: bebida=%b credit=%0d chg=%b expected 0/2/1", BEBIDA, CREDIT, CHG_VALID);
        end
        push_refund(2);
        drain_change(0);
        checks++;
        if (obs_coin.size() != exp_coin.size() || timeout) begin
            errors++;
            $display("FAIL change_count: got %0d coins expected %0d (timeout=%b)", obs_coin.size(), exp_coin.size(), timeout);
        end
        while (exp_coin.size() > 0 && obs_coin.size() > 0) begin
            int ec, oc, er, orr;
            ec = exp_coin.pop_front(); oc = obs_coin.pop_front();
            er = exp_cred.pop_front(); orr = obs_cred.pop_front();
            checks++;
            if (oc != ec || orr != er) begin
                errors++;
                $display("FAIL change_coin: coin=%0d credit=%0d expected %0d/%0d", oc, orr, ec, er);
            end
        end
        exp_coin.delete(); exp_cred.delete();
        checks++;
        if (BUSY !== 1'b0 || CREDIT !== 8'd0) begin
            errors++;
            $display("FAIL change_idle: busy=%b credit=%0d expected 0/0", BUSY, CREDIT);
        end
    endtask

    task automatic test_cancel();
        drive_coin(2'b11);
        drive_coin(2'b10);
        drive_coin(2'b01);
        checks++;
        if (CREDIT !== 8'd17) begin
            errors++;
            $display("FAIL cancel_credit: got %0d expected 17", CREDIT);
        end
        push_refund(17);
        drive_cancel();
        checks++;
        if (CHG_VALID !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL cancel_start: chg=%b busy=%b expected 1/1", CHG_VALID, BUSY);
        end
        drain_change(3);
        checks++;
        if (obs_coin.size() != exp_coin.size() || timeout || unstable) begin
            errors++;
            $display("FAIL cancel_seq: coins=%0d expected %0d timeout=%b unstable=%b expected 0/0",
                     obs_coin.size(), exp_coin.size(), timeout, unstable);
        end
        while (exp_coin.size() > 0 && obs_coin.size() > 0) begin
            int ec, oc, er, orr;
            ec = exp_coin.pop_front(); oc = obs_coin.pop_front();
            er = exp_cred.pop_front(); orr = obs_cred.pop_front();
            checks++;
            if (oc != ec || orr != er) begin
                errors++;
                $display("FAIL cancel_coin: coin=%0d credit=%0d expected %0d/%0d", oc, orr, ec, er);
            end
        end
        exp_coin.delete(); exp_cred.delete();
    endtask

    task automatic test_ceiling();
        int v;
        drive_coin(2'b11);
        drive_coin(2'b11);
        checks++;
        if (CREDIT !== 8'd20 || COIN_REJ !== 1'b0) begin
            errors++;
            $display("FAIL ceil_full: credit=%0d rej=%b expected 20/0", CREDIT, COIN_REJ);
        end
        drive_coin(2'b00);
        checks++;
        if (CREDIT !== 8'd20 || COIN_REJ !== 1'b1) begin
            errors++;
            $display("FAIL ceil_reject: credit=%0d rej=%b expected 20/1", CREDIT, COIN_REJ);
        end
        @(negedge CLK);
        checks++;
        if (COIN_REJ !== 1'b0) begin
            errors++;
            $display("FAIL ceil_pulse: rej=%b expected 0", COIN_REJ);
        end
        exp_vend.push_back(3);
        drive_sel(2'd3);
        v = exp_vend.pop_front();
        checks++;
        if (BEBIDA !== 1'b1 || BEBIDA_ID !== 2'(v)) begin
            errors++;
            $display("FAIL ceil_vend: bebida=%b id=%0d expected 1/%0d", BEBIDA, BEBIDA_ID, v);
        end
        drive_coin(2'b01);
        checks++;
        if (COIN_REJ !== 1'b1 || CREDIT !== 8'd20 || BEBIDA !== 1'b1) begin
            errors++;
            $display("FAIL busy_coin: rej=%b credit=%0d bebida=%b expected 1/20/1", COIN_REJ, CREDIT, BEBIDA);
        end
        VEND_READY = 1'b1;
        @(negedge CLK);
        VEND_READY = 1'b0;
        push_refund(5);
        drain_change(1);
        checks++;
        if (obs_coin.size() != exp_coin.size() || timeout || unstable) begin
            errors++;
            $display("FAIL ceil_change: coins=%0d expected %0d timeout=%b unstable=%b", obs_coin.size(), exp_coin.size(), timeout, unstable);
        end
        while (exp_coin.size() > 0 && obs_coin.size() > 0) begin
            int ec, oc, er, orr;
            ec = exp_coin.pop_front(); oc = obs_coin.pop_front();
            er = exp_cred.pop_front(); orr = obs_cred.pop_front();
            checks++;
            if (oc != ec || orr != er) begin
                errors++;
                $display("FAIL ceil_coin: coin=%0d credit=%0d expected %0d/%0d", oc, orr, ec, er);
            end
        end
        exp_coin.delete(); exp_cred.delete();
    endtask

    task automatic test_select();
        drive_coin(2'b10);
        drive_sel(2'd2);
        checks++;
        if (SEL_REJ !== 1'b1 || CREDIT !== 8'd5 || BEBIDA !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL sel_reject: rej=%b credit=%0d bebida=%b busy=%b expected 1/5/0/0", SEL_REJ, CREDIT, BEBIDA, BUSY);
        end
        push_refund(5);
        SEL_ID = 2'd0;
        SEL_VALID = 1'b1;
        CANCEL = 1'b1;
        @(negedge CLK);
        SEL_VALID = 1'b0;
        CANCEL = 1'b0;
        checks++;
        if (CHG_VALID !== 1'b1 || BEBIDA !== 1'b0 || CHG_COIN !== 2'b10) begin
            errors++;
            $display("FAIL cancel_prio: chg=%b bebida=%b coin=%0d expected 1/0/2", CHG_VALID, BEBIDA, CHG_COIN);
        end
        drain_change(0);
        checks++;
        if (obs_coin.size() != exp_coin.size() || timeout) begin
            errors++;
            $display("FAIL prio_count: coins=%0d expected %0d timeout=%b", obs_coin.size(), exp_coin.size(), timeout);
        end
        while (exp_coin.size() > 0 && obs_coin.size() > 0) begin
            int ec, oc, er, orr;
            ec = exp_coin.pop_front(); oc = obs_coin.pop_front();
            er = exp_cred.pop_front(); orr = obs_cred.pop_front();
            checks++;
            if (oc != ec || orr != er) begin
                errors++;
                $display("FAIL prio_coin: coin=%0d credit=%0d expected %0d/%0d", oc, orr, ec, er);
            end
        end
        exp_coin.delete(); exp_cred.delete();
    endtask

    task automatic test_reset_mid();
        drive_coin(2'b11);
        drive_cancel();
        @(negedge CLK);
        checks++;
        if (CHG_VALID !== 1'b1 || CHG_COIN !== 2'b11) begin
            errors++;
            $display("FAIL mid_pending: chg=%b coin=%0d expected 1/3", CHG_VALID, CHG_COIN);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({BEBIDA, BEBIDA_ID, CHG_VALID, CHG_COIN, CREDIT, COIN_REJ, SEL_REJ, BUSY} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0",
                     {BEBIDA, BEBIDA_ID, CHG_VALID, CHG_COIN, CREDIT, COIN_REJ, SEL_REJ, BUSY});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        drive_coin(2'b01);
        checks++;
        if (CREDIT !== 8'd2 || COIN_REJ !== 1'b0 || BUSY !== 1'b0 || CHG_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_recover: credit=%0d rej=%b busy=%b chg=%b expected 2/0/0/0", CREDIT, COIN_REJ, BUSY, CHG_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_cancel();
        test_ceiling();
        test_select();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
